// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v counters, sync/blank
// aligned to sprite ROM latency, and a per-frame pulse with frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_clk,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       h_end;
    logic       v_end;
    logic       hs_raw;
    logic       vs_raw;
    logic       blank_raw;

    assign h_end = (hc == H_LAST);
    assign v_end = (vc == V_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_en      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            pix_en      <= ~pix_en;
            // Evaluated every Clk so the following non-tick edge clears it: one Clk wide.
            frame_start <= pix_en & h_end & v_end;
            if (pix_en) begin
                hc <= h_end ? '0 : hc + 10'd1;
                if (h_end) begin
                    vc <= v_end ? '0 : vc + 10'd1;
                end
                if (h_end && v_end) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        hs_raw    = ~((hc >= HS_FIRST) && (hc <= HS_LAST));
        vs_raw    = ~((vc >= VS_FIRST) && (vc <= VS_LAST));
        blank_raw = (hc < H_VIS) && (vc < V_VIS);
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign {hs, vs, blank} = {hs_raw, vs_raw, blank_raw};
        end else begin : g_delay
            // Each stage holds {hs, vs, blank}; reset value is the inactive pattern.
            logic [2:0] stage [PIPE_DELAY];

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= 3'b110;
                    end
                end else if (pix_en) begin
                    stage[0] <= {hs_raw, vs_raw, blank_raw};
                    for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign {hs, vs, blank} = stage[PIPE_DELAY-1];
        end
    endgenerate

    assign pixel_clk = pix_en;
    assign DrawX     = hc;
    assign DrawY     = vc;
    assign sync      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: one default-timing instance plus two shrunken-timing instances
// (pipe delay 0 and 3) checked every Clk against a behavioural raster model.
module tb_vga_timing_gen;

    localparam int unsigned NI = 3;
    localparam int unsigned S_HV = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int unsigned S_VV = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int unsigned S_HT = S_HV + S_HF + S_HS + S_HB;

    localparam int unsigned HV [NI] = '{640, S_HV, S_HV};
    localparam int unsigned HF [NI] = '{16,  S_HF, S_HF};
    localparam int unsigned HS [NI] = '{96,  S_HS, S_HS};
    localparam int unsigned HB [NI] = '{48,  S_HB, S_HB};
    localparam int unsigned VV [NI] = '{480, S_VV, S_VV};
    localparam int unsigned VF [NI] = '{10,  S_VF, S_VF};
    localparam int unsigned VS [NI] = '{2,   S_VS, S_VS};
    localparam int unsigned VB [NI] = '{33,  S_VB, S_VB};
    localparam int unsigned PD [NI] = '{1,   0,    3};

    typedef struct packed {
        logic       pclk;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       sync;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic       pclk    [NI];
    logic [9:0] draw_x  [NI];
    logic [9:0] draw_y  [NI];
    logic       h_sync  [NI];
    logic       v_sync  [NI];
    logic       blank   [NI];
    logic       c_sync  [NI];
    logic       f_start [NI];
    logic [7:0] f_count [NI];

    vga_timing_gen #(.PIPE_DELAY(1)) u_big (
        .Clk(clk), .Reset_n(rst_n), .pixel_clk(pclk[0]), .DrawX(draw_x[0]), .DrawY(draw_y[0]),
        .hs(h_sync[0]), .vs(v_sync[0]), .blank(blank[0]), .sync(c_sync[0]),
        .frame_start(f_start[0]), .frame_count(f_count[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .PIPE_DELAY(0)
    ) u_small_d0 (
        .Clk(clk), .Reset_n(rst_n), .pixel_clk(pclk[1]), .DrawX(draw_x[1]), .DrawY(draw_y[1]),
        .hs(h_sync[1]), .vs(v_sync[1]), .blank(blank[1]), .sync(c_sync[1]),
        .frame_start(f_start[1]), .frame_count(f_count[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .PIPE_DELAY(3)
    ) u_small_d3 (
        .Clk(clk), .Reset_n(rst_n), .pixel_clk(pclk[2]), .DrawX(draw_x[2]), .DrawY(draw_y[2]),
        .hs(h_sync[2]), .vs(v_sync[2]), .blank(blank[2]), .sync(c_sync[2]),
        .frame_start(f_start[2]), .frame_count(f_count[2])
    );

    int unsigned m_hc [NI], m_vc [NI], m_fc [NI], m_pulses [NI];
    bit          m_pix;
    bit          m_fs [NI];
    logic [2:0]  m_st [NI][4];
    obs_t        sb [$];

    int unsigned n_vec = 0, n_bad = 0;
    int unsigned d_pulses [NI];
    int unsigned vs_low [NI];
    bit          seen_fs [NI];
    bit          wrap_checked = 1'b0;
    bit          rst_done = 1'b0;
    int unsigned rel_cycle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] raw_of(input int unsigned k, input int unsigned h, input int unsigned v);
        logic rh, rv, rb;
        rh = !((h >= HV[k] + HF[k]) && (h < HV[k] + HF[k] + HS[k]));
        rv = !((v >= VV[k] + VF[k]) && (v < VV[k] + VF[k] + VS[k]));
        rb = (h < HV[k]) && (v < VV[k]);
        return {rh, rv, rb};
    endfunction

    function automatic obs_t expect_of(input int unsigned k);
        obs_t       e;
        logic [2:0] sig;
        sig = (PD[k] == 0) ? raw_of(k, m_hc[k], m_vc[k]) : m_st[k][PD[k]-1];
        e.pclk  = m_pix;
        e.x     = 10'(m_hc[k]);
        e.y     = 10'(m_vc[k]);
        e.hs    = sig[2];
        e.vs    = sig[1];
        e.blank = sig[0];
        e.sync  = 1'b0;
        e.fs    = m_fs[k];
        e.fc    = 8'(m_fc[k]);
        return e;
    endfunction

    task automatic model_reset();
        m_pix = 1'b0;
        for (int unsigned k = 0; k < NI; k++) begin
            m_hc[k] = 0; m_vc[k] = 0; m_fc[k] = 0; m_fs[k] = 1'b0;
            for (int unsigned j = 0; j < 4; j++) m_st[k][j] = 3'b110;
        end
    endtask

    task automatic model_edge();
        bit tick, last;
        int unsigned ht, vt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick  = m_pix;
        m_pix = !m_pix;
        for (int unsigned k = 0; k < NI; k++) begin
            ht = HV[k] + HF[k] + HS[k] + HB[k];
            vt = VV[k] + VF[k] + VS[k] + VB[k];
            last = tick && (m_hc[k] == ht - 1) && (m_vc[k] == vt - 1);
            m_fs[k] = last;
            if (tick) begin
                for (int unsigned j = 3; j > 0; j--) m_st[k][j] = m_st[k][j-1];
                m_st[k][0] = raw_of(k, m_hc[k], m_vc[k]);
                if (m_hc[k] == ht - 1) begin
                    m_hc[k] = 0;
                    m_vc[k] = (m_vc[k] == vt - 1) ? 0 : m_vc[k] + 1;
                end else begin
                    m_hc[k] = m_hc[k] + 1;
                end
            end
            if (last) begin
                m_fc[k] = (m_fc[k] + 1) % 256;
                m_pulses[k]++;
            end
        end
    endtask

    task automatic compare_all();
        obs_t e;
        for (int unsigned k = 0; k < NI; k++) begin
            e = sb.pop_front();
            check($sformatf("u%0d.pixel_clk", k),   pclk[k],    e.pclk);
            check($sformatf("u%0d.DrawX", k),       draw_x[k],  e.x);
            check($sformatf("u%0d.DrawY", k),       draw_y[k],  e.y);
            check($sformatf("u%0d.hs", k),          h_sync[k],  e.hs);
            check($sformatf("u%0d.vs", k),          v_sync[k],  e.vs);
            check($sformatf("u%0d.blank", k),       blank[k],   e.blank);
            check($sformatf("u%0d.sync", k),        c_sync[k],  e.sync);
            check($sformatf("u%0d.frame_start", k), f_start[k], e.fs);
            check($sformatf("u%0d.frame_count", k), f_count[k], e.fc);
        end
    endtask

    // Per-frame vs-low duration and frame_count wrap on the small instances.
    task automatic frame_stats();
        for (int unsigned k = 1; k < NI; k++) begin
            if (!rst_n) begin
                vs_low[k] = 0;
            end else begin
                if (f_start[k]) begin
                    d_pulses[k]++;
                    if (seen_fs[k]) check($sformatf("u%0d.vs_low_clks", k), vs_low[k], 2 * S_VS * S_HT);
                    seen_fs[k] = 1'b1;
                    vs_low[k]  = 0;
                    if (k == 1 && d_pulses[k] == 256) begin
                        check("u1.frame_count_wrap", f_count[k], 0);
                        wrap_checked = 1'b1;
                    end
                end
                if (!v_sync[k]) vs_low[k]++;
            end
        end
    endtask

    initial begin
        model_reset();
        for (int unsigned k = 0; k < NI; k++) begin
            m_pulses[k] = 0; d_pulses[k] = 0; vs_low[k] = 0; seen_fs[k] = 1'b0;
        end
        for (int unsigned c = 0; c < 30000; c++) begin
            @(posedge clk);
            model_edge();
            for (int unsigned k = 0; k < NI; k++) sb.push_back(expect_of(k));
            @(negedge clk);
            compare_all();
            frame_stats();
            if (c == 3) rst_n = 1'b1;
            if (!rst_done && rst_n && m_pulses[1] >= 256 && m_fc[1] == 3 && m_hc[1] == 2 && m_vc[1] == 1) begin
                #3 rst_n = 1'b0;
                #1 model_reset();
                for (int unsigned k = 0; k < NI; k++) sb.push_back(expect_of(k));
                compare_all();
                rst_done  = 1'b1;
                rel_cycle = c;
            end
            if (rst_done && !rst_n && c == rel_cycle + 3) rst_n = 1'b1;
            if (rst_done && c == rel_cycle + 300) break;
        end
        check("mid_frame_reset_reached", rst_done, 1);
        check("u1.wrap_reached", wrap_checked, 1);
        for (int unsigned k = 1; k < NI; k++)
            check($sformatf("u%0d.frame_start_pulses", k), d_pulses[k], m_pulses[k]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
